// File: rtl/cpu_pkg.sv
// Shared definitions for the ECNURVCORE fetch stage: default widths, the
// reset vector, FSM state encoding and redirect-priority codes.
package cpu_pkg;

  localparam int          XLEN_DEFAULT      = 32;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Larger code = higher priority; used when comparing buffered redirects.
  typedef enum logic [1:0] {
    PRIO_BR   = 2'd0,
    PRIO_JAL  = 2'd1,
    PRIO_JALR = 2'd2,
    PRIO_TRAP = 2'd3
  } prio_t;

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selection: priority mux, target adders, JALR bit0
// masking, misalign detection of non-trap redirects and priority code.
module pc_target_sel
  import cpu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int IALIGN     = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic            br_en,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic            trap_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] target,
  output logic            redirect,
  output prio_t           prio,
  output logic            bad_align
);

  // Bit that must be clear for a legal fetch address at this alignment.
  function automatic logic align_bit(input logic [XLEN-1:0] addr);
    return (IALIGN == 32) ? addr[1] : addr[0];
  endfunction

  logic signed [XLEN-1:0] imm_s;
  logic        [XLEN-1:0] pc_rel;
  logic        [XLEN-1:0] jalr_sum;
  logic        [XLEN-1:0] seq;

  assign imm_s    = imm;
  assign pc_rel   = pc + imm_s;
  assign jalr_sum = rs1_val + imm_s;
  assign seq      = pc + XLEN'(ILEN_BYTES);

  always_comb begin
    target    = seq;
    redirect  = 1'b1;
    prio      = PRIO_BR;
    if (trap_en) begin
      target = trap_vec;
      prio   = PRIO_TRAP;
    end else if (jalr_en) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
      prio   = PRIO_JALR;
    end else if (jal_en) begin
      target = pc_rel;
      prio   = PRIO_JAL;
    end else if (br_en) begin
      target = pc_rel;
    end else begin
      redirect = 1'b0;
    end
    bad_align = redirect && !trap_en && align_bit(target);
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT control, PC register and a
// single-entry pending-redirect buffer that absorbs redirects during stall.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEFAULT),
  parameter int              IALIGN     = 32,
  parameter int              ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_en,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_link,
  output logic            pc_valid,
  output logic            misalign
);

  state_t          state;
  logic [XLEN-1:0] target;
  logic            redirect;
  prio_t           prio;
  logic            bad_align;
  logic [XLEN-1:0] pend_target;
  prio_t           pend_prio;
  logic            pend_valid;

  pc_target_sel #(
    .XLEN       (XLEN),
    .IALIGN     (IALIGN),
    .ILEN_BYTES (ILEN_BYTES)
  ) u_sel (
    .pc        (pc),
    .br_en     (br_en),
    .jal_en    (jal_en),
    .jalr_en   (jalr_en),
    .trap_en   (trap_en),
    .imm       (imm),
    .rs1_val   (rs1_val),
    .trap_vec  (trap_vec),
    .target    (target),
    .redirect  (redirect),
    .prio      (prio),
    .bad_align (bad_align)
  );

  assign pc_link = pc + XLEN'(ILEN_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      pc_valid   <= 1'b0;
      misalign   <= 1'b0;
      pend_valid <= 1'b0;
      pend_prio  <= PRIO_BR;
    end else begin
      misalign <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (stall) begin
            // Misaligned targets are rejected at capture, so a buffered
            // redirect is always legal when it is finally applied.
            if (redirect && bad_align) begin
              misalign <= 1'b1;
            end else if (redirect && (!pend_valid || prio >= pend_prio)) begin
              pend_target <= target;
              pend_prio   <= prio;
              pend_valid  <= 1'b1;
            end
          end else begin
            pend_valid <= 1'b0;
            if (trap_en) begin
              pc <= target;
            end else begin
              if (pend_valid) begin
                pc <= pend_target;
              end else if (bad_align) begin
                misalign <= 1'b1;
              end else begin
                pc <= target;
              end
              if (halt_req) begin
                state    <= HALT;
                pc_valid <= 1'b0;
              end
            end
          end
        end
        HALT: begin
          if (trap_en) begin
            pc       <= target;
            state    <= RUN;
            pc_valid <= 1'b1;
          end else if (resume) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, br_en, jal_en, jalr_en, trap_en, halt_req, resume;
  logic [31:0] imm, rs1_val, trap_vec;
  logic [31:0] pc, pc_link;
  logic        pc_valid, misalign;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN       (32),
    .RESET_VEC  (32'h0000_0000),
    .IALIGN     (32),
    .ILEN_BYTES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .br_en    (br_en),
    .jal_en   (jal_en),
    .jalr_en  (jalr_en),
    .imm      (imm),
    .rs1_val  (rs1_val),
    .trap_en  (trap_en),
    .trap_vec (trap_vec),
    .halt_req (halt_req),
    .resume   (resume),
    .pc       (pc),
    .pc_link  (pc_link),
    .pc_valid (pc_valid),
    .misalign (misalign)
  );

  task automatic clear_in();
    rst = 0; stall = 0; br_en = 0; jal_en = 0; jalr_en = 0; trap_en = 0;
    halt_req = 0; resume = 0; imm = 0; rs1_val = 0; trap_vec = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Uses a trap redirect to place the PC at a chosen address while in RUN.
  task automatic set_pc(input logic [31:0] v);
    clear_in();
    trap_en = 1; trap_vec = v;
    step();
    clear_in();
    checks++;
    if (pc !== v) begin
      failures++;
      $display("FAIL set_pc: pc=%h expected=%h", pc, v);
    end
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%h valid=%b mis=%b expected pc=0 valid=0 mis=0", pc, pc_valid, misalign);
    end
    step();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b1 || pc_link !== 32'h4) begin
      failures++;
      $display("FAIL boot_to_run: pc=%h valid=%b link=%h expected pc=0 valid=1 link=4", pc, pc_valid, pc_link);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (pc !== 32'(4 * i) || pc_link !== 32'(4 * i + 4) || pc_valid !== 1'b1) begin
        failures++;
        $display("FAIL sequential: pc=%h link=%h expected pc=%h link=%h", pc, pc_link, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_jal_br_misalign();
    set_pc(32'h100);
    jal_en = 1; br_en = 1; imm = 32'h20;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h120 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL jal_br: pc=%h mis=%b expected pc=120 mis=0", pc, misalign);
    end
    set_pc(32'h100);
    jal_en = 1; br_en = 1; jalr_en = 1; rs1_val = 32'h203; imm = 0;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h100 || misalign !== 1'b1) begin
      failures++;
      $display("FAIL jalr_misalign: pc=%h mis=%b expected pc=100 mis=1", pc, misalign);
    end
    step();
    checks++;
    if (pc !== 32'h104 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse: pc=%h mis=%b expected pc=104 mis=0", pc, misalign);
    end
    jalr_en = 1; rs1_val = 32'h301; imm = 32'hFFFF_FFFF;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h300 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL jalr_aligned: pc=%h mis=%b expected pc=300 mis=0", pc, misalign);
    end
  endtask

  task automatic test_stall_trap();
    set_pc(32'h40);
    stall = 1; br_en = 1; imm = 32'h10;
    step();
    checks++;
    if (pc !== 32'h40) begin
      failures++;
      $display("FAIL stall_hold: pc=%h expected=00000040", pc);
    end
    br_en = 0; trap_en = 1; trap_vec = 32'h800;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h40) begin
      failures++;
      $display("FAIL stall_trap_hold: pc=%h expected=00000040", pc);
    end
    step();
    checks++;
    if (pc !== 32'h800) begin
      failures++;
      $display("FAIL pend_trap: pc=%h expected=00000800", pc);
    end
    step();
    checks++;
    if (pc !== 32'h804) begin
      failures++;
      $display("FAIL pend_trap_seq: pc=%h expected=00000804", pc);
    end
  endtask

  task automatic test_pending_wins();
    set_pc(32'h40);
    stall = 1; br_en = 1; imm = 32'h10;
    step();
    clear_in();
    jal_en = 1; imm = 32'h100;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h50) begin
      failures++;
      $display("FAIL pend_wins: pc=%h expected=00000050", pc);
    end
    step();
    checks++;
    if (pc !== 32'h54) begin
      failures++;
      $display("FAIL pend_wins_seq: pc=%h expected=00000054", pc);
    end
    // A lower-priority branch must not overwrite a buffered JAL.
    set_pc(32'h40);
    stall = 1; jal_en = 1; imm = 32'h100;
    step();
    jal_en = 0; br_en = 1; imm = 32'h8;
    step();
    clear_in();
    step();
    checks++;
    if (pc !== 32'h140) begin
      failures++;
      $display("FAIL pend_priority: pc=%h expected=00000140", pc);
    end
  endtask

  task automatic test_halt();
    set_pc(32'h200);
    halt_req = 1;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h204 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_entry: pc=%h valid=%b expected pc=204 valid=0", pc, pc_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pc !== 32'h204 || pc_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold: pc=%h valid=%b expected pc=204 valid=0", pc, pc_valid);
      end
    end
    resume = 1;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h204 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL resume: pc=%h valid=%b expected pc=204 valid=1", pc, pc_valid);
    end
    step();
    checks++;
    if (pc !== 32'h208) begin
      failures++;
      $display("FAIL resume_seq: pc=%h expected=00000208", pc);
    end
    halt_req = 1;
    step();
    clear_in();
    step();
    checks++;
    if (pc !== 32'h20C || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_again: pc=%h valid=%b expected pc=20c valid=0", pc, pc_valid);
    end
    trap_en = 1; trap_vec = 32'h800;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h800 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL halt_trap: pc=%h valid=%b expected pc=800 valid=1", pc, pc_valid);
    end
    halt_req = 1; trap_en = 1; trap_vec = 32'h300;
    step();
    clear_in();
    step();
    checks++;
    if (pc !== 32'h304 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL trap_over_halt: pc=%h valid=%b expected pc=304 valid=1", pc, pc_valid);
    end
  endtask

  task automatic test_wrap_and_reset_pending();
    set_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_link !== 32'h0) begin
      failures++;
      $display("FAIL wrap_link: link=%h expected=00000000", pc_link);
    end
    step();
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc: pc=%h expected=00000000", pc);
    end
    stall = 1; br_en = 1; imm = 32'h10;
    step();
    rst = 1;
    step();
    clear_in();
    checks++;
    if (pc !== 32'h0 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stall: pc=%h valid=%b expected pc=0 valid=0", pc, pc_valid);
    end
    step();
    step();
    checks++;
    if (pc !== 32'h4 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL pend_discarded: pc=%h valid=%b expected pc=4 valid=1", pc, pc_valid);
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_jal_br_misalign();
    test_stall_trap();
    test_pending_wins();
    test_halt();
    test_wrap_and_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
